// File: rtl/ttrng_pkg.sv
// Shared constants and types for the TRNG von Neumann collector.
package ttrng_pkg;

    // Width of one collected output byte.
    localparam int BYTE_W = 8;

    // Width of the bit-position counter inside the byte assembler.
    localparam int BIT_CNT_W = $clog2(BYTE_W);

    // Debiaser pair tracking: waiting for the first or the second bit of a pair.
    typedef enum logic {
        PAIR_IDLE  = 1'b0,
        PAIR_HAVE1 = 1'b1
    } pair_state_t;

endpackage : ttrng_pkg

// File: rtl/ttrng_byte_fifo.sv
// Small byte FIFO holding whitened entropy bytes until the consumer takes them.
// The head byte is shown combinationally and reads as zero while the FIFO is empty.
module ttrng_byte_fifo
    import ttrng_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [BYTE_W-1:0]       push_data,
    input  logic                    pop,
    output logic [BYTE_W-1:0]       head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Reject depths the power-of-two pointer wrap cannot handle.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ttrng_byte_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when the same edge also frees a slot by popping.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage array is written only on accepted pushes and needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; the count tracks net pushes minus pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : ttrng_byte_fifo

// File: rtl/ttrng_vn_collector.sv
// Von Neumann debiaser for a raw latch-network entropy stream. Unequal sample
// pairs yield one bit (01 -> 0, 10 -> 1); bits are packed LSB-first into bytes
// that are queued in a small FIFO for the consumer.
module ttrng_vn_collector
    import ttrng_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    raw_bit,
    input  logic                    raw_valid,
    output logic [BYTE_W-1:0]       data_out,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    input  logic                    clr_overflow
);

    pair_state_t            state;
    logic                   first_bit;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0]      assembler;
    logic [BYTE_W-1:0]      assembler_next;

    logic                   sample_ok;
    logic                   emit;
    logic                   byte_done;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;

    // The second sample of an unequal pair emits the first sample's value,
    // which is exactly the 01 -> 0, 10 -> 1 mapping.
    assign sample_ok = en && raw_valid;
    assign emit      = sample_ok && (state == PAIR_HAVE1) && (first_bit != raw_bit);
    assign byte_done = emit && (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

    // Assembler contents with the bit being emitted this cycle already merged,
    // so a completing byte can be pushed on the same edge.
    always_comb begin
        assembler_next          = assembler;
        assembler_next[bit_cnt] = first_bit;
    end

    // When the FIFO is full, the consumer's pop is the only thing that can make room.
    assign drop       = byte_done && fifo_full && !data_ready;
    assign data_valid = !fifo_empty;

    // Pair FSM, bit counter and assembler; disabling clears any partial pair or byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PAIR_IDLE;
            first_bit <= 1'b0;
            bit_cnt   <= '0;
            assembler <= '0;
        end else if (!en) begin
            state   <= PAIR_IDLE;
            bit_cnt <= '0;
        end else if (raw_valid) begin
            case (state)
                PAIR_IDLE: begin
                    first_bit <= raw_bit;
                    state     <= PAIR_HAVE1;
                end
                PAIR_HAVE1: begin
                    state <= PAIR_IDLE;
                    if (emit) begin
                        assembler <= assembler_next;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                default: state <= PAIR_IDLE;
            endcase
        end
    end

    // Sticky overflow: a dropped byte sets it, and set beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    ttrng_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (byte_done),
        .push_data (assembler_next),
        .pop       (data_ready),
        .head_data (data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule : ttrng_vn_collector

// File: tb/tb_ttrng_vn_collector.sv
// Directed testbench for the von Neumann collector with hand-computed bytes.
module tb_ttrng_vn_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       clr_overflow = 1'b0;

    int n_compared = 0;
    int n_mismatched = 0;

    ttrng_vn_collector #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .raw_bit      (raw_bit),
        .raw_valid    (raw_valid),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // One raw sample presented for exactly one rising edge; returns 1 ns after that edge.
    task automatic sample(input logic b);
        @(negedge clk);
        raw_bit   = b;
        raw_valid = 1'b1;
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
    endtask

    // Sample whose edge also carries the given data_ready / clr_overflow values.
    task automatic sample_ctl(input logic b, input logic rdy, input logic clr);
        @(negedge clk);
        raw_bit      = b;
        raw_valid    = 1'b1;
        data_ready   = rdy;
        clr_overflow = clr;
        @(posedge clk);
        #1;
        raw_valid    = 1'b0;
        data_ready   = 1'b0;
        clr_overflow = 1'b0;
    endtask

    // Emits bit v through an unequal pair: 10 for 1, 01 for 0.
    task automatic send_pair(input logic v);
        sample(v);
        sample(~v);
    endtask

    // Emits bits 0..n-1 of b, LSB first.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            send_pair(b[i]);
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_compared++;
        if (data_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_valid: got %0b want 0", data_valid);
        end
        n_compared++;
        if (fifo_count !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_count: got %0d want 0", fifo_count);
        end
        n_compared++;
        if (data_out !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data: got %h want 00", data_out);
        end
        n_compared++;
        if (overflow !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_overflow: got %0b want 0", overflow);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pairs 10,01,10,10,01,01,10,01 emit 1,0,1,1,0,0,1,0 -> LSB-first 8'h4D.
    task automatic test_basic_byte();
        logic [7:0] firsts;
        firsts = 8'b0100_1101;
        en = 1'b1;
        data_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_pair(firsts[i]);
        end
        sample(firsts[7]);
        n_compared++;
        if (data_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_early_valid: got %0b want 0", data_valid);
        end
        sample(~firsts[7]);
        n_compared++;
        if (data_valid !== 1'b1 || data_out !== 8'h4D) begin
            n_mismatched++;
            $display("[TB] FAIL basic_byte: got valid=%0b data=%h want valid=1 data=4d", data_valid, data_out);
        end
        @(posedge clk);
        #1;
        n_compared++;
        if (fifo_count !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_popped: got count=%0d want 0", fifo_count);
        end
        data_ready = 1'b0;
    endtask

    // Equal pairs 00 and 11 between the same unequal pairs change nothing.
    task automatic test_equal_pairs();
        logic [7:0] firsts;
        firsts = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            sample(i[0]);
            sample(i[0]);
            send_pair(firsts[i]);
        end
        n_compared++;
        if (data_valid !== 1'b1 || data_out !== 8'h4D || fifo_count !== 3'd1) begin
            n_mismatched++;
            $display("[TB] FAIL equal_pairs: got valid=%0b data=%h count=%0d want 1/4d/1", data_valid, data_out, fifo_count);
        end
        pop_one();
    endtask

    // Five bytes into a depth-4 FIFO: fifth dropped, first four drain in order.
    task automatic test_overflow();
        logic [7:0] exp_bytes [4];
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_bits(exp_bytes[i], 8);
        end
        n_compared++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_fill: got count=%0d ovf=%0b want 4/0", fifo_count, overflow);
        end
        send_bits(8'h55, 8);
        n_compared++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1 || data_out !== 8'h11) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_drop: got count=%0d ovf=%0b data=%h want 4/1/11", fifo_count, overflow, data_out);
        end
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (data_out !== exp_bytes[i]) begin
                n_mismatched++;
                $display("[TB] FAIL ovf_drain%0d: got %h want %h", i, data_out, exp_bytes[i]);
            end
            pop_one();
        end
        n_compared++;
        if (data_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_empty: got valid=%0b count=%0d ovf=%0b want 0/0/1", data_valid, fifo_count, overflow);
        end
        @(negedge clk);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        n_compared++;
        if (overflow !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_clear: got %0b want 0", overflow);
        end
    endtask

    // Drop and clear on the same edge: the drop wins.
    task automatic test_set_wins();
        send_bits(8'hAA, 8);
        send_bits(8'hBB, 8);
        send_bits(8'hCC, 8);
        send_bits(8'hDD, 8);
        send_bits(8'hEE, 7);
        sample(1'b1);
        sample_ctl(1'b0, 1'b0, 1'b1);
        n_compared++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4 || data_out !== 8'hAA) begin
            n_mismatched++;
            $display("[TB] FAIL set_wins: got ovf=%0b count=%0d data=%h want 1/4/aa", overflow, fifo_count, data_out);
        end
    endtask

    // Full FIFO with a pop on the completing edge: push and pop both happen.
    task automatic test_full_push_pop();
        logic [7:0] exp_bytes [4];
        exp_bytes = '{8'hBB, 8'hCC, 8'hDD, 8'h99};
        @(negedge clk);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        send_bits(8'h99, 7);
        sample(1'b1);
        sample_ctl(1'b0, 1'b1, 1'b0);
        n_compared++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0 || data_out !== 8'hBB) begin
            n_mismatched++;
            $display("[TB] FAIL full_push_pop: got count=%0d ovf=%0b data=%h want 4/0/bb", fifo_count, overflow, data_out);
        end
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (data_out !== exp_bytes[i]) begin
                n_mismatched++;
                $display("[TB] FAIL wrap_drain%0d: got %h want %h", i, data_out, exp_bytes[i]);
            end
            pop_one();
        end
    endtask

    // Disable mid-byte: partial bits are discarded, FIFO still drains while disabled.
    task automatic test_enable();
        do_reset();
        send_bits(8'h5A, 8);
        send_bits(8'hFF, 5);
        sample(1'b1);
        @(negedge clk);
        en = 1'b0;
        send_pair(1'b1);
        send_pair(1'b0);
        n_compared++;
        if (fifo_count !== 3'd1 || data_out !== 8'h5A) begin
            n_mismatched++;
            $display("[TB] FAIL en_hold: got count=%0d data=%h want 1/5a", fifo_count, data_out);
        end
        pop_one();
        n_compared++;
        if (data_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL en_drain: got valid=%0b want 0", data_valid);
        end
        @(negedge clk);
        en = 1'b1;
        send_bits(8'hA6, 8);
        n_compared++;
        if (fifo_count !== 3'd1 || data_out !== 8'hA6) begin
            n_mismatched++;
            $display("[TB] FAIL en_fresh_byte: got count=%0d data=%h want 1/a6", fifo_count, data_out);
        end
    endtask

    // Asynchronous reset mid-pair with two stored bytes.
    task automatic test_reset_mid();
        do_reset();
        send_bits(8'h81, 8);
        send_bits(8'h7E, 8);
        sample(1'b1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_compared++;
        if (data_valid !== 1'b0 || fifo_count !== 3'd0 || data_out !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: got valid=%0b count=%0d data=%h want 0/0/00", data_valid, fifo_count, data_out);
        end
        #1;
        rst = 1'b0;
        send_bits(8'hC3, 7);
        n_compared++;
        if (data_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_no_early: got valid=%0b want 0", data_valid);
        end
        send_pair(1'b1);
        n_compared++;
        if (data_valid !== 1'b1 || data_out !== 8'hC3) begin
            n_mismatched++;
            $display("[TB] FAIL reset_new_byte: got valid=%0b data=%h want 1/c3", data_valid, data_out);
        end
    endtask

    // Run all scenarios in order and report.
    initial begin
        $display("[TB] starting ttrng_vn_collector tests");
        test_reset();
        test_basic_byte();
        test_equal_pairs();
        test_overflow();
        test_set_wins();
        test_full_push_pop();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_ttrng_vn_collector
